// File: rtl/pe_mac_unit.sv
// Processing element: per-PE weight/activation register files plus a two-stage signed
// multiply-accumulate pipeline feeding the partial-sum write-back path.
module pe_mac_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_w,
  input  logic                     write_a,
  input  logic                     shift,
  input  logic                     comp,
  input  logic                     clear,
  input  logic [2:0]               write_idx,
  input  logic [2:0]               comp_idx,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [DATA_W-1:0] a_in,
  output logic signed [ACC_W-1:0]  psum,
  output logic                     psum_vld,
  output logic                     busy,
  output logic                     ovf
);

  logic signed [DATA_W-1:0]   r_weight [DEPTH];
  logic signed [DATA_W-1:0]   r_act    [DEPTH];
  logic signed [2*DATA_W-1:0] r_prod;
  logic                       r_s1_vld;
  logic signed [ACC_W-1:0]    r_psum;
  logic                       r_psum_vld;
  logic                       r_ovf;

  logic signed [DATA_W-1:0]   w_wop;
  logic signed [DATA_W-1:0]   w_aop;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic                       w_ovf;

  // Register files: shift first, then a same-cycle write at write_idx overrides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_weight[i] <= '0;
        r_act[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (write_w && (write_idx == 3'(i))) begin
          r_weight[i] <= w_in;
        end
        if (write_a && (write_idx == 3'(i))) begin
          r_act[i] <= a_in;
        end else if (shift) begin
          r_act[i] <= (i == DEPTH - 1) ? '0 : r_act[(i + 1) % DEPTH];
        end
      end
    end
  end

  // Operand select with write bypass; indices outside the file read as zero.
  always_comb begin
    w_wop = '0;
    w_aop = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (comp_idx == 3'(i)) begin
        w_wop = (write_w && (write_idx == comp_idx)) ? w_in : r_weight[i];
        w_aop = (write_a && (write_idx == comp_idx)) ? a_in : r_act[i];
      end
    end
  end

  assign w_prod = w_wop * w_aop;
  assign w_ext  = ACC_W'(r_prod);
  assign w_sum  = r_psum + w_ext;
  assign w_ovf  = (r_psum[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_psum[ACC_W-1]);

  // Stage 1 always accepts comp, so a comp alongside clear is the first term after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod     <= '0;
      r_s1_vld   <= 1'b0;
      r_psum     <= '0;
      r_psum_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_s1_vld <= comp;
      if (comp) begin
        r_prod <= w_prod;
      end
      if (clear) begin
        r_psum     <= '0;
        r_psum_vld <= 1'b0;
        r_ovf      <= 1'b0;
      end else begin
        r_psum_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_psum <= w_sum;
          if (w_ovf) begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  assign psum     = r_psum;
  assign psum_vld = r_psum_vld;
  assign busy     = r_s1_vld;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_pe_mac_unit.sv
// Directed bench for pe_mac_unit: a 24-bit accumulator instance and a 16-bit instance
// sharing the same stimulus, the latter used for the wrap/overflow case.
module tb_pe_mac_unit;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              write_w, write_a, shift, comp, clear;
  logic [2:0]        write_idx, comp_idx;
  logic signed [7:0] w_in, a_in;

  logic signed [23:0] psum;
  logic               psum_vld, busy, ovf;
  logic signed [15:0] psum16;
  logic               psum_vld16, busy16, ovf16;

  int n_cmp = 0;
  int n_mis = 0;
  int vld_cnt;

  always #5 clk = ~clk;

  pe_mac_unit #(.DATA_W(8), .ACC_W(24), .DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .write_w(write_w), .write_a(write_a), .shift(shift),
    .comp(comp), .clear(clear), .write_idx(write_idx), .comp_idx(comp_idx),
    .w_in(w_in), .a_in(a_in), .psum(psum), .psum_vld(psum_vld), .busy(busy), .ovf(ovf)
  );

  pe_mac_unit #(.DATA_W(8), .ACC_W(16), .DEPTH(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .write_w(write_w), .write_a(write_a), .shift(shift),
    .comp(comp), .clear(clear), .write_idx(write_idx), .comp_idx(comp_idx),
    .w_in(w_in), .a_in(a_in), .psum(psum16), .psum_vld(psum_vld16), .busy(busy16),
    .ovf(ovf16)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_w = 1'b0; write_a = 1'b0; shift = 1'b0; comp = 1'b0; clear = 1'b0;
    write_idx = '0; comp_idx = '0; w_in = '0; a_in = '0;
  endtask

  task automatic wr(input int idx, input int w, input int a, input bit ww, input bit wa);
    idle();
    write_w = ww; write_a = wa; write_idx = 3'(idx); w_in = 8'(w); a_in = 8'(a);
    step();
    idle();
  endtask

  task automatic do_comp(input int idx);
    idle();
    comp = 1'b1; comp_idx = 3'(idx);
    step();
    idle();
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    step();
    idle();
  endtask

  initial begin
    idle();
    #2;
    check("reset_psum", psum, 0);
    check("reset_vld", psum_vld, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);
    #1 rst_n = 1'b1;
    step();

    // Dot product of 1..8 with itself, back-to-back comps.
    for (int i = 0; i < 8; i++) wr(i, i + 1, i + 1, 1'b1, 1'b1);
    vld_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle(); comp = 1'b1; comp_idx = 3'(i);
      step();
      if (i == 0) check("busy_first", busy, 1);
      vld_cnt += int'(psum_vld);
    end
    idle();
    step();
    vld_cnt += int'(psum_vld);
    check("dot_204", psum, 204);
    step();
    vld_cnt += int'(psum_vld);
    check("vld_pulses", vld_cnt, 8);
    check("idle_busy", busy, 0);

    // Shift with a same-cycle write to the vacated top slot.
    do_clear();
    check("clear_psum", psum, 0);
    idle(); shift = 1'b1; write_a = 1'b1; write_idx = 3'd7; a_in = 8'sd9;
    step();
    for (int i = 0; i < 8; i++) begin
      idle(); comp = 1'b1; comp_idx = 3'(i);
      step();
    end
    idle();
    step();
    step();
    check("shift_240", psum, 240);

    // Activation write bypass into a same-cycle comp.
    do_clear();
    wr(3, -4, 0, 1'b1, 1'b0);
    idle(); write_a = 1'b1; write_idx = 3'd3; a_in = 8'sd5; comp = 1'b1; comp_idx = 3'd3;
    step();
    idle();
    step();
    step();
    check("bypass_a", psum, -20);
    do_clear();
    idle(); write_w = 1'b1; write_idx = 3'd3; w_in = 8'sd1; comp = 1'b1; comp_idx = 3'd3;
    step();
    idle();
    step();
    step();
    check("act3_kept_bypass_w", psum, 5);

    // Clear together with a comp: that product is the first term afterwards.
    do_clear();
    wr(0, 10, 10, 1'b1, 1'b1);
    do_comp(0);
    step();
    step();
    check("psum_100", psum, 100);
    wr(1, 2, 3, 1'b1, 1'b1);
    idle(); clear = 1'b1; comp = 1'b1; comp_idx = 3'd1;
    step();
    idle();
    check("clrcomp_psum0", psum, 0);
    check("clrcomp_vld0", psum_vld, 0);
    check("clrcomp_busy", busy, 1);
    step();
    check("clrcomp_psum6", psum, 6);
    check("clrcomp_vld1", psum_vld, 1);
    check("clrcomp_ovf", ovf, 0);

    // A product in stage 1 when clear hits is dropped.
    do_comp(1);
    do_clear();
    check("drop_psum", psum, 0);
    step();
    check("drop_psum_after", psum, 0);
    check("drop_vld", psum_vld, 0);

    // 16-bit accumulator wrap and sticky overflow.
    do_clear();
    wr(0, 127, 127, 1'b1, 1'b1);
    idle(); comp = 1'b1; comp_idx = 3'd0;
    step();
    check("wrap_p0", psum16, 0);
    step();
    check("wrap_p1", psum16, 16129);
    step();
    check("wrap_p2", psum16, 32258);
    check("wrap_ovf_pre", ovf16, 0);
    idle();
    step();
    check("wrap_p3", psum16, -17149);
    check("wrap_ovf_set", ovf16, 1);
    do_comp(0);
    step();
    check("wrap_p4", psum16, -1020);
    check("wrap_ovf_sticky", ovf16, 1);
    check("wide_no_wrap", psum, 64516);
    check("wide_ovf", ovf, 0);
    do_clear();
    check("wrap_ovf_cleared", ovf16, 0);

    // Reset while a product is in flight.
    do_comp(4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_psum", psum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vld_cnt += int'(psum_vld);
    end
    check("rst_no_vld", vld_cnt, 0);
    check("rst_psum_held", psum, 0);
    wr(2, 7, 0, 1'b1, 1'b0);
    do_comp(2);
    step();
    step();
    check("rst_act_zero", psum, 0);
    wr(4, 0, 6, 1'b0, 1'b1);
    do_comp(4);
    step();
    step();
    check("rst_weight_zero", psum, 0);
    wr(2, 0, 3, 1'b0, 1'b1);
    do_comp(2);
    step();
    step();
    check("post_rst_mac", psum, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
